icache_refill_ctrl: RTL and testbench

Sequencer for the instruction cache's line refill and invalidation. On a fetch miss it pulls a full 16-word line from instruction memory one word at a time over a valid/ready request and valid response handshake. It writes each word into the cache data array, then commits the tag and valid bit. It also runs a full-cache invalidation sweep on request. It sits between the cache lookup logic (miss source, array write ports) and the instruction memory.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_word_ctr.sv | 25 ++
 rtl/icache_refill_ctrl.sv | 106 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared I-cache geometry, refill FSM states and address field helpers
package icache_pkg;
  localparam int LINE_WORDS = 16;
  localparam int INDEX_W = 6;
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 32 - INDEX_W - WORD_W - 2;
  typedef enum logic [2:0] {IDLE, START, REQ, WAIT, COMMIT, FLUSH} state_e;
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction
  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[WORD_W+2 +: INDEX_W];
  endfunction
  function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
    return a[2 +: WORD_W];
  endfunction
endpackage

// File: rtl/icache_word_ctr.sv
// icache_word_ctr: loadable modulo-LINE_WORDS word counter; last flags the word before the start point
module icache_word_ctr
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] start,
  input  logic              inc,
  output logic [WORD_W-1:0] word,
  output logic              last
);
  logic [WORD_W-1:0] first;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      word <= '0;
      first <= '0;
    end else if (load) begin
      word <= start;
      first <= start;
    end else if (inc) begin
      word <= word + WORD_W'(1);
    end
  assign last = (word + WORD_W'(1)) == first;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: I-cache line refill and full invalidation sequencer.
// ICACHE_CWF_EN: fetch critical word first and wrap; otherwise words 0..LINE_WORDS-1.
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  input  logic [31:0]        miss_addr,
  output logic               miss_ready,
  input  logic               flush,
  output logic               mem_req_valid,
  output logic [31:0]        mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [31:0]        mem_rsp_data,
  output logic               fill_we,
  output logic [INDEX_W-1:0] fill_index,
  output logic [WORD_W-1:0]  fill_word,
  output logic [31:0]        fill_data,
  output logic               tag_we,
  output logic [INDEX_W-1:0] tag_index,
  output logic [TAG_W-1:0]   tag_value,
  output logic               valid_bit,
  output logic               crit_valid,
  output logic [31:0]        crit_data,
  output logic               busy,
  output logic               flush_done
);
  state_e state, state_n;
  logic [TAG_W-1:0] tag;
  logic [INDEX_W-1:0] index, flush_idx;
  logic [WORD_W-1:0] crit, word, start_word;
  logic last, done, accept, take;
  assign miss_ready = reset && state == IDLE && !flush;
  assign accept = miss_valid && miss_ready;
  assign take = state == WAIT && mem_rsp_valid && !done;
`ifdef ICACHE_CWF_EN
  assign start_word = addr_word(miss_addr);
`else
  assign start_word = '0;
`endif
  icache_word_ctr u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .start (start_word),
    .inc   (take),
    .word  (word),
    .last  (last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // done holds WAIT one extra cycle so the last fill_we lands before COMMIT's tag write
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tag <= '0;
      index <= '0;
      crit <= '0;
      flush_idx <= '0;
      done <= 1'b0;
      fill_we <= 1'b0;
      fill_word <= '0;
      fill_data <= '0;
      crit_valid <= 1'b0;
      crit_data <= '0;
      flush_done <= 1'b0;
    end else begin
      if (accept) begin
        tag <= addr_tag(miss_addr);
        index <= addr_index(miss_addr);
        crit <= addr_word(miss_addr);
      end
      flush_idx <= state == FLUSH ? flush_idx + INDEX_W'(1) : '0;
      done <= take && last;
      fill_we <= take;
      crit_valid <= take && word == crit;
      flush_done <= state == FLUSH && &flush_idx;
      if (take) begin
        fill_word <= word;
        fill_data <= mem_rsp_data;
      end
      if (take && word == crit) crit_data <= mem_rsp_data;
    end
  always_comb begin
    state_n = state;
    mem_req_valid = 1'b0;
    tag_we = 1'b0;
    tag_index = index;
    tag_value = '0;
    valid_bit = 1'b0;
    case (state)
      IDLE:    state_n = flush ? FLUSH : accept ? START : IDLE;
      START:   begin tag_we = 1'b1; state_n = REQ; end
      REQ:     begin mem_req_valid = 1'b1; state_n = mem_req_ready ? WAIT : REQ; end
      WAIT:    state_n = done ? COMMIT : take ? (last ? WAIT : REQ) : WAIT;
      COMMIT:  begin tag_we = 1'b1; tag_value = tag; valid_bit = 1'b1; state_n = IDLE; end
      FLUSH:   begin tag_we = 1'b1; tag_index = flush_idx; state_n = &flush_idx ? IDLE : FLUSH; end
      default: state_n = IDLE;
    endcase
  end
  assign mem_req_addr = {tag, index, word, 2'b00};
  assign fill_index = index;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized refill/flush bench checked against a transaction-level model
module tb_icache_refill_ctrl;
  import icache_pkg::*;
  logic clk = 1'b0, reset = 1'b1, miss_valid = 1'b0, flush = 1'b0;
  logic mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] miss_addr = '0, mem_rsp_data = '0;
  logic miss_ready, mem_req_valid, fill_we, tag_we, valid_bit, crit_valid, busy, flush_done;
  logic [31:0] mem_req_addr, fill_data, crit_data;
  logic [INDEX_W-1:0] fill_index, tag_index;
  logic [WORD_W-1:0] fill_word;
  logic [TAG_W-1:0] tag_value;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .flush(flush), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .fill_we(fill_we),
    .fill_index(fill_index), .fill_word(fill_word), .fill_data(fill_data),
    .tag_we(tag_we), .tag_index(tag_index), .tag_value(tag_value), .valid_bit(valid_bit),
    .crit_valid(crit_valid), .crit_data(crit_data), .busy(busy), .flush_done(flush_done)
  );

`ifdef ICACHE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct { int cyc; logic [63:0] v; } ev_t;
  ev_t tag_q[$], fill_q[$], crit_q[$];
  int done_q[$];
  logic [31:0] req_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit pending = 0, hs = 0, in_req = 0, spur = 0;
  logic [31:0] pend_addr = '0, req_addr0 = '0, key = '0;
  int rsp_wait = 0, ready_wait = 0, max_rdy = 0, max_rsp = 0, hold_at = -1, hold_len = 0, sum_delay = 0;

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_ctl"}, 64'({mem_req_valid, fill_we, tag_we, valid_bit, crit_valid, busy,
                          flush_done, miss_ready, mem_req_addr}), 64'(0));
    chk({t, "_idx"}, 64'({fill_index, fill_word, tag_index, tag_value}), 64'(0));
    chk({t, "_data"}, {fill_data, crit_data}, 64'(0));
  endtask

  // one clock: log DUT strobes, then play the memory (one outstanding read, random latencies)
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (fill_we) fill_q.push_back('{cyc, 64'({fill_index, fill_word, fill_data})});
    if (tag_we) tag_q.push_back('{cyc, 64'({tag_index, tag_value, valid_bit})});
    if (crit_valid) crit_q.push_back('{cyc, 64'({fill_we, fill_word, crit_data})});
    if (flush_done) done_q.push_back(cyc);
    if (mem_rsp_valid && pending) pending = 0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    if (hs) begin
      hs = 0;
      pending = 1;
      req_q.push_back(pend_addr);
      rsp_wait = int'($urandom_range(max_rsp, 0));
      sum_delay += rsp_wait;
    end
    if (pending) begin
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = pend_addr ^ key;
      end else rsp_wait--;
    end else if (mem_req_valid) begin
      if (!in_req) begin
        in_req = 1;
        req_addr0 = mem_req_addr;
        ready_wait = (req_q.size() == hold_at) ? hold_len : int'($urandom_range(max_rdy, 0));
        sum_delay += ready_wait;
      end else chk("req_addr_stable", 64'(mem_req_addr), 64'(req_addr0));
      if (ready_wait == 0) begin
        mem_req_ready = 1'b1;
        hs = 1;
        in_req = 0;
        pend_addr = mem_req_addr;
      end else begin
        ready_wait--;
        mem_rsp_valid = spur && $urandom_range(1, 0) == 1;
        mem_rsp_data = $urandom;
      end
    end else if (!busy) begin
      mem_rsp_valid = spur && $urandom_range(1, 0) == 1;
      mem_rsp_data = $urandom;
    end
  endtask

  task automatic check_refill(input logic [31:0] a, input int acc);
    logic [3:0] crit;
    logic [31:0] ea;
    int p;
    crit = a[5:2];
    chk("tag_writes", 64'(tag_q.size()), 64'(2));
    chk("fill_writes", 64'(fill_q.size()), 64'(16));
    chk("req_count", 64'(req_q.size()), 64'(16));
    chk("crit_pulses", 64'(crit_q.size()), 64'(1));
    if (tag_q.size() == 2) begin
      chk("start_inval", tag_q[0].v, 64'({a[11:6], 20'h0, 1'b0}));
      chk("start_cycle", 64'(tag_q[0].cyc - acc), 64'(0));
      chk("commit_tag", tag_q[1].v, 64'({a[11:6], a[31:12], 1'b1}));
      chk("commit_cycle", 64'(tag_q[1].cyc - acc), 64'(34 + sum_delay));
    end
    for (int k = 0; k < 16; k++) begin
      ea = {a[31:6], CWF ? crit + 4'(k) : 4'(k), 2'b00};
      if (k < req_q.size()) chk("req_addr", 64'(req_q[k]), 64'(ea));
      if (k < fill_q.size()) chk("fill", fill_q[k].v, 64'({a[11:6], ea[5:2], ea ^ key}));
    end
    if (fill_q.size() == 16 && tag_q.size() == 2)
      chk("fill_window", 64'({fill_q[0].cyc > tag_q[0].cyc, fill_q[15].cyc < tag_q[1].cyc}), 64'(3));
    p = CWF ? 0 : int'(crit);
    if (crit_q.size() == 1 && fill_q.size() == 16) begin
      chk("crit_align", 64'(crit_q[0].cyc), 64'(fill_q[p].cyc));
      chk("crit_data", crit_q[0].v, 64'({1'b1, crit, {a[31:6], crit, 2'b00} ^ key}));
    end
  endtask

  task automatic do_miss(input logic [31:0] a);
    int acc;
    tag_q.delete(); fill_q.delete(); crit_q.delete(); req_q.delete();
    sum_delay = 0;
    miss_addr = a;
    miss_valid = 1'b1;
    for (int i = 0; i < 200 && !busy; i++) tick();
    chk("miss_accepted", 64'(busy), 64'(1));
    acc = cyc;
    miss_valid = 1'b0;
    for (int i = 0; i < 3000 && tag_q.size() < 2; i++) tick();
    check_refill(a, acc);
    tick();
    chk("idle_after_commit", 64'({busy, miss_ready}), 64'(1));
  endtask

  initial begin
    logic [31:0] b;
    reset = 1'b0;
    #1;
    chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("post_reset_ready", 64'({miss_ready, busy}), 64'(2));
    do_miss(32'h0000_1034);
    do_miss(32'h0000_0034);
    hold_at = 3;
    hold_len = 5;
    do_miss(32'hABCD_E5F8);
    hold_at = -1;
    spur = 1;
    max_rdy = 3;
    max_rsp = 3;
    for (int n = 0; n < 6; n++) begin
      key = $urandom;
      do_miss($urandom);
    end
    // flush and miss raised together: flush wins, miss follows
    tag_q.delete(); done_q.delete(); fill_q.delete();
    b = $urandom;
    flush = 1'b1;
    miss_valid = 1'b1;
    miss_addr = b;
    #1;
    chk("flush_blocks_miss", 64'(miss_ready), 64'(0));
    for (int i = 0; i < 20 && !busy; i++) tick();
    flush = 1'b0;
    for (int i = 0; i < 200 && done_q.size() == 0; i++) tick();
    chk("flush_writes", 64'(tag_q.size()), 64'(64));
    for (int i = 0; i < tag_q.size() && i < 64; i++)
      chk("flush_line", (64'(tag_q[i].cyc - tag_q[0].cyc) << 32) | tag_q[i].v,
          (64'(i) << 32) | 64'({6'(i), 20'h0, 1'b0}));
    chk("flush_done_cnt", 64'(done_q.size()), 64'(1));
    if (done_q.size() == 1 && tag_q.size() == 64)
      chk("flush_done_time", 64'(done_q[0] - tag_q[63].cyc), 64'(1));
    chk("flush_no_fill", 64'(fill_q.size()), 64'(0));
    chk("ready_after_flush", 64'(miss_ready), 64'(1));
    do_miss(b);
    // reset during the third WAIT, then refetch the same line
    tag_q.delete(); fill_q.delete(); crit_q.delete(); req_q.delete();
    b = $urandom;
    miss_addr = b;
    miss_valid = 1'b1;
    for (int i = 0; i < 200 && !busy; i++) tick();
    miss_valid = 1'b0;
    for (int i = 0; i < 500 && !(req_q.size() == 3 && pending); i++) tick();
    chk("third_wait", 64'(req_q.size()), 64'(3));
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    chk("partial_no_commit", 64'(tag_q.size()), 64'(1));
    chk("partial_fills", 64'(fill_q.size()), 64'(2));
    pending = 0; hs = 0; in_req = 0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("release_ready", 64'({miss_ready, busy}), 64'(2));
    do_miss(b);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
